// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed, XOR-checksummed
// byte stream and turns it into one-cycle word writes at consecutive addresses.
module imem_loader #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX_VALID,
    input  logic [7:0]  RX_DATA,
    output logic        RX_READY,
    output logic        WE,
    output logic [31:0] WADDR,
    output logic [31:0] WDATA,
    output logic        DONE,
    output logic        ERR
);

    localparam int CW = $clog2(MEM_WORDS + 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [31:0]     r_n;
    logic [7:0]      r_csum;
    logic [1:0]      r_byteIdx;
    logic [CW-1:0]   r_wordCnt;
    logic [23:0]     r_word;
    logic            r_we;
    logic [31:0]     r_waddr;
    logic [31:0]     r_wdata;

    logic            w_loadState;
    logic            w_accept;
    logic [31:0]     w_hdrN;
    logic            w_lastWord;

    // Ready is masked by RST so a byte presented during reset is never handshaken.
    assign w_loadState = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign RX_READY    = w_loadState && !RST;
    assign w_accept    = RX_VALID && RX_READY;
    assign w_hdrN      = {RX_DATA, r_n[23:0]};
    assign w_lastWord  = (32'(r_wordCnt) + 32'd1) == r_n;

    assign WE    = r_we;
    assign WADDR = r_waddr;
    assign WDATA = r_wdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        DONE        = 1'b0;
        ERR         = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_accept && r_byteIdx == 2'd3) begin
                    if (w_hdrN > 32'(MEM_WORDS)) begin
                        w_nextState = S_ERROR;
                    end else if (w_hdrN == 32'd0) begin
                        w_nextState = S_CSUM;
                    end else begin
                        w_nextState = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && r_byteIdx == 2'd3 && w_lastWord) begin
                    w_nextState = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_nextState = (RX_DATA == r_csum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE: begin
                DONE = 1'b1;
            end
            S_ERROR: begin
                ERR = 1'b1;
            end
            default: begin
                w_nextState = S_HDR;
            end
        endcase
    end

    // The fourth byte of a word goes straight into WDATA, so the write strobe lands
    // exactly one cycle after that byte is accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_n       <= 32'd0;
            r_csum    <= 8'd0;
            r_byteIdx <= 2'd0;
            r_wordCnt <= '0;
            r_word    <= 24'd0;
            r_we      <= 1'b0;
            r_waddr   <= BASE_ADDR;
            r_wdata   <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                r_byteIdx <= r_byteIdx + 2'd1;
                case (r_state)
                    S_HDR: begin
                        r_n[8*r_byteIdx +: 8] <= RX_DATA;
                    end
                    S_DATA: begin
                        r_csum <= r_csum ^ RX_DATA;
                        case (r_byteIdx)
                            2'd0: r_word[7:0]   <= RX_DATA;
                            2'd1: r_word[15:8]  <= RX_DATA;
                            2'd2: r_word[23:16] <= RX_DATA;
                            default: begin
                                r_we      <= 1'b1;
                                r_wdata   <= {RX_DATA, r_word};
                                r_waddr   <= BASE_ADDR + (32'(r_wordCnt) << 2);
                                r_wordCnt <= r_wordCnt + 1'b1;
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of image scenarios with $urandom payloads checked
// against a byte-stream image model, plus hand sequences for reset abort and terminal hold.
module tb_imem_loader;

    localparam int          MEMW = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        CLK;
    logic        RST;
    logic        RX_VALID;
    logic [7:0]  RX_DATA;
    logic        RX_READY;
    logic        WE;
    logic [31:0] WADDR;
    logic [31:0] WDATA;
    logic        DONE;
    logic        ERR;

    imem_loader #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST(RST), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
        .RX_READY(RX_READY), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .DONE(DONE), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int nHdr;
        int nWords;
        bit fixedImg;
        bit badCsum;
        int gapMode;
        bit expDone;
        bit expErr;
        int expWrites;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bothHigh = 0;

    logic [31:0] gotAddr[$];
    logic [31:0] gotData[$];
    int          gotEdge[$];
    int          accEdge[$];
    logic [7:0]  txBytes[$];
    logic [31:0] expWords[$];
    logic [31:0] fixedWords[3];
    vec_t        vecs[9];

    always @(posedge CLK) cyc <= cyc + 1;

    // Observation is done mid-cycle; an accept seen here completes on the next edge.
    always @(negedge CLK) begin
        if (RX_VALID && RX_READY) accEdge.push_back(cyc + 1);
        if (WE) begin
            gotAddr.push_back(WADDR);
            gotData.push_back(WDATA);
            gotEdge.push_back(cyc);
        end
        if (DONE && ERR) bothHigh++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic clearMonitor();
        gotAddr.delete();
        gotData.delete();
        gotEdge.delete();
        accEdge.delete();
    endtask

    task automatic doReset();
        RST      = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_ready", {31'd0, RX_READY}, 32'd0);
        checkOutput("rst_we",    {31'd0, WE},       32'd0);
        checkOutput("rst_done",  {31'd0, DONE},     32'd0);
        checkOutput("rst_err",   {31'd0, ERR},      32'd0);
        checkOutput("rst_waddr", WADDR,             BASE);
        checkOutput("rst_wdata", WDATA,             32'd0);
        RST = 1'b0;
        #1;
        checkOutput("ready_after_rst", {31'd0, RX_READY}, 32'd1);
    endtask

    // Image model: header, little-endian words, XOR of payload bytes only.
    task automatic buildImage(input int nHdr, input int nWords, input bit fixedImg, input bit badCsum);
        logic [31:0] hdr;
        logic [31:0] w;
        logic [7:0]  cs;
        txBytes.delete();
        expWords.delete();
        hdr = 32'(nHdr);
        for (int b = 0; b < 4; b++) txBytes.push_back(hdr[8*b +: 8]);
        if (nHdr > MEMW) return;
        cs = 8'h00;
        for (int k = 0; k < nWords; k++) begin
            w = fixedImg ? fixedWords[k] : $urandom;
            expWords.push_back(w);
            for (int b = 0; b < 4; b++) begin
                txBytes.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        if (badCsum) txBytes.push_back((cs == 8'h00) ? 8'hFF : 8'h00);
        else         txBytes.push_back(cs);
    endtask

    task automatic sendByte(input logic [7:0] b, input int idle);
        bit rdy;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < idle; i++) begin
            RX_VALID = 1'b0;
            @(posedge CLK);
            #1;
        end
        RX_VALID = 1'b1;
        RX_DATA  = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            rdy = RX_READY;
            @(posedge CLK);
            #1;
            if (rdy) ok = 1'b1;
        end
        RX_VALID = 1'b0;
        if (!ok) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input int gapMode, input int count);
        int idle;
        for (int i = 0; i < count; i++) begin
            idle = 0;
            if (gapMode == 1 && i > 0) idle = 1;
            if (gapMode == 2) idle = int'($urandom_range(0, 2));
            sendByte(txBytes[i], idle);
        end
    endtask

    task automatic checkWrites(input string tag, input int expCount);
        int n;
        checkOutput({tag, "_wrcount"}, 32'(gotAddr.size()), 32'(expCount));
        n = (gotAddr.size() < expWords.size()) ? gotAddr.size() : expWords.size();
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s_addr%0d", tag, k), gotAddr[k], BASE + 32'(4 * k));
            checkOutput($sformatf("%s_data%0d", tag, k), gotData[k], expWords[k]);
            if (4 * k + 7 < accEdge.size())
                checkOutput($sformatf("%s_wetime%0d", tag, k), 32'(gotEdge[k]), 32'(accEdge[4 * k + 7]));
            else
                checkOutput($sformatf("%s_wetime%0d", tag, k), 32'(gotEdge[k]), 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        RST      = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        fixedWords[0] = 32'h0000_0013;
        fixedWords[1] = 32'h00A0_0293;
        fixedWords[2] = 32'h0200_0313;

        vecs[0] = '{3, 3, 1'b1, 1'b0, 0, 1'b1, 1'b0, 3};
        vecs[1] = '{3, 3, 1'b1, 1'b1, 0, 1'b0, 1'b1, 3};
        vecs[2] = '{0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0};
        vecs[3] = '{MEMW + 1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 0};
        vecs[4] = '{2, 2, 1'b0, 1'b0, 1, 1'b1, 1'b0, 2};
        vecs[5] = '{5, 5, 1'b0, 1'b0, 0, 1'b1, 1'b0, 5};
        vecs[6] = '{4, 4, 1'b0, 1'b1, 2, 1'b0, 1'b1, 4};
        vecs[7] = '{MEMW, MEMW, 1'b0, 1'b0, 0, 1'b1, 1'b0, MEMW};
        vecs[8] = '{7, 7, 1'b0, 1'b0, 2, 1'b1, 1'b0, 7};

        for (int v = 0; v < 9; v++) begin
            doReset();
            buildImage(vecs[v].nHdr, vecs[v].nWords, vecs[v].fixedImg, vecs[v].badCsum);
            clearMonitor();
            applyStimulus(vecs[v].gapMode, txBytes.size());
            checkOutput($sformatf("v%0d_done", v), {31'd0, DONE}, {31'd0, vecs[v].expDone});
            checkOutput($sformatf("v%0d_err", v),  {31'd0, ERR},  {31'd0, vecs[v].expErr});
            repeat (3) @(posedge CLK);
            #1;
            checkOutput($sformatf("v%0d_ready_term", v), {31'd0, RX_READY}, 32'd0);
            checkWrites($sformatf("v%0d", v), vecs[v].expWrites);
        end

        // Abort a load after 6 bytes; the byte offered during reset must be dropped.
        doReset();
        buildImage(2, 2, 1'b0, 1'b0);
        clearMonitor();
        applyStimulus(0, 6);
        RST      = 1'b1;
        RX_VALID = 1'b1;
        RX_DATA  = 8'hAB;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        RX_VALID = 1'b0;
        #1;
        checkOutput("abort_ready", {31'd0, RX_READY}, 32'd1);
        checkOutput("abort_nowrites", 32'(gotAddr.size()), 32'd0);
        buildImage(1, 1, 1'b0, 1'b0);
        clearMonitor();
        applyStimulus(0, txBytes.size());
        checkOutput("abort_done", {31'd0, DONE}, 32'd1);
        checkOutput("abort_err",  {31'd0, ERR},  32'd0);
        @(posedge CLK);
        #1;
        checkWrites("abort", 1);

        // Terminal DONE must ignore further traffic.
        clearMonitor();
        for (int i = 0; i < 10; i++) begin
            RX_VALID = 1'b1;
            RX_DATA  = 8'($urandom);
            @(posedge CLK);
            #1;
            checkOutput($sformatf("hold_ready%0d", i), {31'd0, RX_READY}, 32'd0);
            checkOutput($sformatf("hold_we%0d", i),    {31'd0, WE},       32'd0);
            checkOutput($sformatf("hold_done%0d", i),  {31'd0, DONE},     32'd1);
        end
        RX_VALID = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("hold_nowrites", 32'(gotAddr.size()), 32'd0);
        checkOutput("done_err_exclusive", 32'(bothHigh), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
